fir_output_stage: RTL and testbench
===================================

// Module: fir_output_stage
// PURPOSE
//  Consumes the cascade accumulator (cascout) of the last mac tap in the FIR chain.
//  Discards the pipeline-fill results, rounds and saturates each full-width result
//  to DSIZE bits, and buffers them in a small FIFO with a valid/ready output.
//  Downstream (echo mixer, DAC interface) may stall without losing samples, up to DEPTH.
// PARAMETERS
//  DSIZE  16  output sample width; input accumulator is 2*DSIZE bits
//  SHIFT  15  arithmetic right shift applied after rounding (0..2*DSIZE-1)
//  FILL   17  number of acc_valid samples discarded after reset/clr (0..255)
//  DEPTH  4   output FIFO depth, power of two, >=2
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  clr        in   1        synchronous flush: FIFO, fill counter, overflow
//  acc_in     in   2*DSIZE  signed accumulator from last mac cascout
//  acc_valid  in   1        acc_in is a new result this cycle
//  out_data   out  DSIZE    signed rounded/saturated sample at FIFO head
//  out_valid  out  1        FIFO non-empty
//  out_ready  in   1        consumer accepts out_data when out_valid&&out_ready
//  overflow   out  1        sticky: a sample was dropped because FIFO was full
//  sat_count  out  16       saturation event counter (FIR_SAT_CNT_EN only)
// BEHAVIOUR
//  Reset (rst=1, async): out_valid=0, out_data=0, overflow=0, sat_count=0,
//   fill counter=0, FIFO empty, pipeline valids=0.
//  Fill: the first FILL acc_valid samples after reset/clr are dropped at S1 entry.
//   The counter saturates at FILL. Every later acc_valid sample enters the pipe.
//  S1 (edge N): r1 <= acc_in + (SHIFT>0 ? 2**(SHIFT-1) : 0), computed at 2*DSIZE+1
//   bits, sign-extended (no wrap). v1 <= accepted.
//  S2 (edge N+1): t = r1 >>> SHIFT; clamp to [-2**(DSIZE-1), 2**(DSIZE-1)-1].
//   Rounding is round-half-up (toward +inf on ties). v2 <= v1.
//  FIFO write at edge N+2 when v2. A sample accepted at edge N is visible on
//   out_data/out_valid after edge N+2 if the FIFO was empty. Latency is 2 cycles.
//  out_data is the registered FIFO head, valid only when out_valid=1. out_data holds
//   the head while out_valid&&!out_ready. Pop occurs on out_valid&&out_ready.
//  Simultaneous push and pop: occupancy is unchanged. When full, the pop frees the slot
//   and the push is accepted (no overflow). When empty, only the push applies.
//  Push while full without a pop: the sample is discarded, overflow<=1, FIFO unchanged.
//  The pointers wrap modulo DEPTH, with one extra bit to tell full from empty.
//  clr=1 (sync, wins over all): FIFO empty, out_valid=0, fill counter=0, v1=v2=0,
//   overflow=0, sat_count=0. The acc_valid sample arriving in the same cycle is dropped.
//  Reset mid-operation clears in-flight S1/S2 samples. No partial output.
//  The clamp is applied only to valid S2 samples. Invalid stages never touch the FIFO
//   or the counter.
// CONFIGURATION
//  FIR_SAT_CNT_EN defined: sat_count increments by 1 for each valid S2 sample that is
//   clamped (pos or neg), whether or not it is later dropped. It saturates at 16'hFFFF.
//  FIR_SAT_CNT_EN undefined: the port is present and tied to 16'h0. No counter logic.
// TESTING (DSIZE=16, SHIFT=15, DEPTH=4, FILL=3 unless stated)
//  1 Fill: rst, then 5 valid samples 1..5<<15. Only 4 and 5 appear, 2 cycles after
//    each is accepted; out_ready=1.
//  2 Rounding (FILL=0): acc 0x0000_4000->0x0001; 0x0000_3FFF->0x0000;
//    0xFFFF_C000->0x0000; 0xFFFF_BFFF->0xFFFF.
//  3 Saturation: 0x7FFF_FFFF->0x7FFF; 0x8000_0000->0x8000; 0x4000_0000->0x7FFF.
//    With FIR_SAT_CNT_EN, sat_count=3. Without it, sat_count=0.
//  4 Backpressure: out_ready=0, 5 samples pushed. Entries 1-4 are held, the 5th is
//    dropped, overflow=1. Then out_ready=1 pops 1-4 in order over 4 cycles;
//    out_valid falls, overflow stays 1.
//  5 Full + simultaneous: FIFO full, and push coincides with pop. No drop, overflow=0,
//    occupancy stays 4, order is preserved.
//  6 clr/rst mid-stream: assert clr with 2 samples in flight and 3 in the FIFO.
//    Next cycle out_valid=0 and overflow=0, and FILL samples are dropped again.
//    Repeat with async rst pulsed between edges: outputs clear immediately.

Source files
------------

// File: rtl/fir_output_stage_if.sv
// fir_output_stage_if: accumulator input and valid/ready sample output of the FIR output stage.
interface fir_output_stage_if #(parameter int DSIZE = 16);
  logic signed [2*DSIZE-1:0] acc_in;
  logic acc_valid;
  logic signed [DSIZE-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic overflow;
  logic [15:0] sat_count;
  modport master (output acc_in, acc_valid, out_ready, input out_data, out_valid, overflow, sat_count);
  modport slave (input acc_in, acc_valid, out_ready, output out_data, out_valid, overflow, sat_count);
endinterface

// File: rtl/fir_output_stage.sv
// fir_output_stage: drop fill samples, round/saturate cascade accumulator, buffer in valid/ready FIFO.
// Optional saturation counter enabled by defining FIR_SAT_CNT_EN.
module fir_output_stage #(
  parameter int DSIZE = 16,
  parameter int SHIFT = 15,
  parameter int FILL = 17,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic clr,
  fir_output_stage_if.slave bus
);
  localparam int W = 2*DSIZE;
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [W:0] RND = SHIFT > 0 ? (W+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  localparam logic signed [W:0] MAXV = {{(DSIZE+2){1'b0}}, {(DSIZE-1){1'b1}}};
  localparam logic signed [W:0] MINV = {{(DSIZE+2){1'b1}}, {(DSIZE-1){1'b0}}};
  localparam logic [DSIZE-1:0] DMAX = {1'b0, {(DSIZE-1){1'b1}}};
  localparam logic [DSIZE-1:0] DMIN = {1'b1, {(DSIZE-1){1'b0}}};
  logic [7:0] fill_cnt;
  logic v1, v2, ovf;
  logic signed [W:0] r1, t;
  logic [DSIZE-1:0] d2;
  logic [DSIZE-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic fill_done, accept, sat_pos, sat_neg, empty, full, pop, push;
  always_comb begin
    fill_done = fill_cnt == 8'(FILL);
    accept = bus.acc_valid && fill_done;
    t = r1 >>> SHIFT;
    sat_pos = t > MAXV;
    sat_neg = t < MINV;
    empty = wp == rp;
    full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    pop = !empty && bus.out_ready;
    push = v2 && (!full || pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst || clr) begin
      fill_cnt <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      r1 <= '0;
      d2 <= '0;
      wp <= '0;
      rp <= '0;
      ovf <= 1'b0;
    end else begin
      if (bus.acc_valid && !fill_done) fill_cnt <= fill_cnt + 8'd1;
      v1 <= accept;
      // widened by one bit so the rounding offset cannot wrap the accumulator
      if (accept) r1 <= {bus.acc_in[W-1], bus.acc_in} + RND;
      v2 <= v1;
      if (v1) d2 <= sat_pos ? DMAX : sat_neg ? DMIN : t[DSIZE-1:0];
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (v2 && !push) ovf <= 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '{default: '0};
    else if (push && !clr) mem[wp[AW-1:0]] <= d2;
  assign bus.out_data = mem[rp[AW-1:0]];
  assign bus.out_valid = !empty;
  assign bus.overflow = ovf;
`ifdef FIR_SAT_CNT_EN
  logic [15:0] sat_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst || clr) sat_cnt <= '0;
    else if (v1 && (sat_pos || sat_neg) && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
  assign bus.sat_count = sat_cnt;
`else
  assign bus.sat_count = 16'h0;
`endif
endmodule

// File: tb/tb_fir_output_stage.sv
// tb_fir_output_stage: randomized bench with a queue-based reference model of the output stage.
module tb_fir_output_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int checks = 0;
  int failures = 0;
  int fill;
  bit pv0, pv1, ps0, ovf;
  logic [15:0] pd0, pd1, hd;
  logic [15:0] q[$];
  int sat;
  fir_output_stage_if #(.DSIZE(16)) bus();
  fir_output_stage #(.DSIZE(16), .SHIFT(15), .FILL(3), .DEPTH(4)) dut (.clk(clk), .rst(rst), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [16:0] ref_sample(input logic [31:0] acc);
    longint a = longint'($signed(acc));
    longint r = (a + 16384) >>> 15;
    if (r > 32767) return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(r)};
  endfunction
  function automatic logic [31:0] rnd_acc();
    logic [31:0] r = $urandom;
    return $urandom_range(0, 3) == 0 ? r : {{8{r[23]}}, r[23:0]};
  endfunction
  task automatic model_reset();
    fill = 0;
    pv0 = 0;
    pv1 = 0;
    q.delete();
    ovf = 0;
    sat = 0;
  endtask
  // advance the reference model by one clock edge with the current inputs, then step the DUT
  task automatic tick();
    logic [16:0] s;
    if (rst || clr) model_reset();
    else begin
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (pv1) begin
        if (q.size() < 4) q.push_back(pd1);
        else ovf = 1;
      end
`ifdef FIR_SAT_CNT_EN
      if (pv0 && ps0 && sat < 65535) sat++;
`endif
      pv1 = pv0;
      pd1 = pd0;
      s = ref_sample(bus.acc_in);
      pv0 = bus.acc_valid && fill == 3;
      ps0 = s[16];
      pd0 = s[15:0];
      if (bus.acc_valid && fill < 3) fill++;
    end
    @(posedge clk);
    #1;
    hd = q.size() > 0 ? q[0] : 16'h0;
  endtask
  task automatic test_reset();
    rst = 1;
    bus.acc_valid = 0;
    bus.acc_in = '0;
    bus.out_ready = 0;
    tick();
    tick();
    checks++;
    if ({bus.out_valid, bus.out_data, bus.overflow, bus.sat_count} !== 34'h0) begin
      failures++;
      $display("FAIL reset: got v=%b d=%h ovf=%b sat=%h, want all zero", bus.out_valid, bus.out_data, bus.overflow, bus.sat_count);
    end
    rst = 0;
    tick();
  endtask
  task automatic test_fill();
    logic [15:0] got[$];
    bus.out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      bus.acc_valid = c < 5;
      bus.acc_in = 32'(c + 1) << 15;
      tick();
      checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.overflow !== ovf || bus.sat_count !== 16'(sat) || (bus.out_valid && bus.out_data !== hd)) begin
        failures++;
        $display("FAIL fill c=%0d: got v=%b d=%h ovf=%b sat=%0d, want v=%b d=%h ovf=%b sat=%0d", c, bus.out_valid, bus.out_data, bus.overflow, bus.sat_count, q.size() > 0, hd, ovf, sat);
      end
      if (bus.out_valid) got.push_back(bus.out_data);
    end
    checks++;
    if (got.size() != 2 || got[0] !== 16'd4 || got[1] !== 16'd5) begin
      failures++;
      $display("FAIL fill_seq: got %0d samples first=%h, want 2 samples 0004 0005", got.size(), got.size() > 0 ? got[0] : 16'hxxxx);
    end
  endtask
  task automatic test_rounding();
    logic [31:0] vals[4] = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'hFFFF_BFFF};
    logic [15:0] want[4] = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    logic [15:0] got[$];
    clr = 1;
    tick();
    clr = 0;
    bus.out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      bus.acc_valid = c < 7;
      bus.acc_in = c < 3 ? rnd_acc() : vals[c < 7 ? c - 3 : 0];
      tick();
      checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.overflow !== ovf || bus.sat_count !== 16'(sat) || (bus.out_valid && bus.out_data !== hd)) begin
        failures++;
        $display("FAIL round c=%0d: got v=%b d=%h ovf=%b sat=%0d, want v=%b d=%h ovf=%b sat=%0d", c, bus.out_valid, bus.out_data, bus.overflow, bus.sat_count, q.size() > 0, hd, ovf, sat);
      end
      if (bus.out_valid) got.push_back(bus.out_data);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== want[i]) begin
        failures++;
        $display("FAIL round_val%0d: got %h, want %h", i, got.size() > i ? got[i] : 16'hxxxx, want[i]);
      end
    end
  endtask
  task automatic test_saturation();
    logic [31:0] vals[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000};
    logic [15:0] want[3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
    logic [15:0] got[$];
    logic [15:0] exp_sc;
`ifdef FIR_SAT_CNT_EN
    exp_sc = 16'd3;
`else
    exp_sc = 16'd0;
`endif
    clr = 1;
    tick();
    clr = 0;
    bus.out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      bus.acc_valid = c < 6;
      bus.acc_in = c < 3 ? 32'h7FFF_FFFF : vals[c < 6 ? c - 3 : 0];
      tick();
      checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.overflow !== ovf || bus.sat_count !== 16'(sat) || (bus.out_valid && bus.out_data !== hd)) begin
        failures++;
        $display("FAIL sat c=%0d: got v=%b d=%h ovf=%b sat=%0d, want v=%b d=%h ovf=%b sat=%0d", c, bus.out_valid, bus.out_data, bus.overflow, bus.sat_count, q.size() > 0, hd, ovf, sat);
      end
      if (bus.out_valid) got.push_back(bus.out_data);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== want[i]) begin
        failures++;
        $display("FAIL sat_val%0d: got %h, want %h", i, got.size() > i ? got[i] : 16'hxxxx, want[i]);
      end
    end
    checks++;
    if (bus.sat_count !== exp_sc) begin
      failures++;
      $display("FAIL sat_count: got %0d, want %0d", bus.sat_count, exp_sc);
    end
  endtask
  task automatic test_backpressure();
    logic [15:0] sent[$];
    logic [15:0] got[$];
    logic [16:0] s;
    clr = 1;
    tick();
    clr = 0;
    bus.out_ready = 0;
    for (int c = 0; c < 18; c++) begin
      bus.acc_valid = c < 8;
      bus.acc_in = rnd_acc();
      s = ref_sample(bus.acc_in);
      if (c >= 3 && c < 8) sent.push_back(s[15:0]);
      if (c == 11) bus.out_ready = 1;
      tick();
      checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.overflow !== ovf || bus.sat_count !== 16'(sat) || (bus.out_valid && bus.out_data !== hd)) begin
        failures++;
        $display("FAIL bp c=%0d: got v=%b d=%h ovf=%b sat=%0d, want v=%b d=%h ovf=%b sat=%0d", c, bus.out_valid, bus.out_data, bus.overflow, bus.sat_count, q.size() > 0, hd, ovf, sat);
      end
      if (c == 10) begin
        checks++;
        if (bus.overflow !== 1'b1 || bus.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_full: got ovf=%b v=%b, want ovf=1 v=1", bus.overflow, bus.out_valid);
        end
      end
      if (c >= 10 && bus.out_valid) got.push_back(bus.out_data);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== sent[i]) begin
        failures++;
        $display("FAIL bp_order%0d: got %h, want %h", i, got.size() > i ? got[i] : 16'hxxxx, sent[i]);
      end
    end
    checks++;
    if (got.size() != 4 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain: got n=%0d v=%b ovf=%b, want n=4 v=0 ovf=1", got.size(), bus.out_valid, bus.overflow);
    end
  endtask
  task automatic test_full_simul();
    clr = 1;
    tick();
    clr = 0;
    for (int c = 0; c < 24; c++) begin
      bus.acc_valid = c < 15;
      bus.acc_in = rnd_acc();
      bus.out_ready = c >= 9;
      tick();
      checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.overflow !== ovf || bus.sat_count !== 16'(sat) || (bus.out_valid && bus.out_data !== hd)) begin
        failures++;
        $display("FAIL full c=%0d: got v=%b d=%h ovf=%b sat=%0d, want v=%b d=%h ovf=%b sat=%0d", c, bus.out_valid, bus.out_data, bus.overflow, bus.sat_count, q.size() > 0, hd, ovf, sat);
      end
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_noovf: got ovf=%b, want 0", bus.overflow);
    end
  endtask
  task automatic test_clr_rst_mid();
    clr = 1;
    tick();
    clr = 0;
    bus.out_ready = 0;
    for (int c = 0; c < 8; c++) begin
      bus.acc_valid = 1;
      bus.acc_in = rnd_acc();
      tick();
    end
    clr = 1;
    tick();
    clr = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL clr_mid: got v=%b ovf=%b, want v=0 ovf=0", bus.out_valid, bus.overflow);
    end
    bus.out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      bus.acc_valid = c < 3;
      bus.acc_in = rnd_acc();
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.overflow !== ovf || bus.sat_count !== 16'(sat)) begin
        failures++;
        $display("FAIL clr_refill c=%0d: got v=%b ovf=%b sat=%0d, want v=0 ovf=%b sat=%0d", c, bus.out_valid, bus.overflow, bus.sat_count, ovf, sat);
      end
    end
    bus.out_ready = 0;
    for (int c = 0; c < 10; c++) begin
      bus.acc_valid = c < 7;
      bus.acc_in = rnd_acc();
      tick();
    end
    checks++;
    if (bus.overflow !== 1'b1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: got ovf=%b v=%b, want ovf=1 v=1", bus.overflow, bus.out_valid);
    end
    bus.acc_valid = 1;
    #2 rst = 1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.overflow, bus.sat_count} !== 34'h0) begin
      failures++;
      $display("FAIL rst_async: got v=%b d=%h ovf=%b sat=%h, want all zero", bus.out_valid, bus.out_data, bus.overflow, bus.sat_count);
    end
    #1 rst = 0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      bus.acc_valid = $urandom_range(0, 1);
      bus.acc_in = rnd_acc();
      tick();
      checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.overflow !== ovf || bus.sat_count !== 16'(sat) || (bus.out_valid && bus.out_data !== hd)) begin
        failures++;
        $display("FAIL rst_after c=%0d: got v=%b d=%h ovf=%b sat=%0d, want v=%b d=%h ovf=%b sat=%0d", c, bus.out_valid, bus.out_data, bus.overflow, bus.sat_count, q.size() > 0, hd, ovf, sat);
      end
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.acc_valid = $urandom_range(0, 3) != 0;
      bus.acc_in = rnd_acc();
      bus.out_ready = $urandom_range(0, 2) != 0;
      clr = $urandom_range(0, 60) == 0;
      tick();
      checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.overflow !== ovf || bus.sat_count !== 16'(sat) || (bus.out_valid && bus.out_data !== hd)) begin
        failures++;
        $display("FAIL random c=%0d: got v=%b d=%h ovf=%b sat=%0d, want v=%b d=%h ovf=%b sat=%0d", c, bus.out_valid, bus.out_data, bus.overflow, bus.sat_count, q.size() > 0, hd, ovf, sat);
      end
    end
    clr = 0;
  endtask
  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_full_simul();
    test_clr_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
